mips_out_capture: RTL and testbench

Downstream observer for the MIPS core's `mipsOut`/`overflow` outputs.
- Samples both every clock and detects result events.
- Timestamps each event with a free-running cycle counter and buffers it in a first-word-fall-through FIFO.
- Drains entries through a valid/ready read port, so a bench or debug host can read the core's result trace at its own rate without missing changes.

---
 rtl/mips_out_capture.sv | 104 ++++++++++
 tb/tb_mips_out_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_out_capture.sv
// Timestamped FWFT trace buffer for the MIPS core's result bus and overflow flag.
// An entry pushed at edge t is on the read port from cycle t+1; a push into a full FIFO with no pop is dropped and flagged.
module mips_out_capture #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      mipsOut,
  input  logic                   overflow,
  input  logic                   capEn,
  input  logic                   clr,
  input  logic                   rdReady,
  output logic                   rdValid,
  output logic [DATA_W-1:0]      rdData,
  output logic [CNT_W-1:0]       rdStamp,
  output logic                   rdOvf,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   dropped,
  output logic                   ovfSticky,
  output logic [CNT_W-1:0]       cycleCnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [CNT_W-1:0]  stamp;
    logic              ovf;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  entry_t            wr_entry;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       occ;
  logic [DATA_W-1:0] prev_out;
  logic              prev_ovf;
  logic              hit;
  logic              do_push;
  logic              do_pop;
  logic              lost;

  assign rdValid = (occ != '0);
  assign full    = (occ == DEPTH_CNT);
  assign count   = occ;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  always_comb begin
    hit      = capEn && ((mipsOut != prev_out) || (overflow && !prev_ovf));
    do_pop   = rdValid && rdReady && !clr;
    do_push  = hit && !clr && (!full || do_pop);
    lost     = hit && !clr && full && !do_pop;
    wr_entry = '{dat: mipsOut, stamp: cycleCnt, ovf: overflow};
  end

  assign head    = mem[rd_ptr];
  assign rdData  = rdValid ? head.dat   : '0;
  assign rdStamp = rdValid ? head.stamp : '0;
  assign rdOvf   = rdValid ? head.ovf   : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleCnt  <= '0;
      prev_out  <= '0;
      prev_ovf  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      dropped   <= 1'b0;
      ovfSticky <= 1'b0;
    end else begin
      cycleCnt <= cycleCnt + CNT_W'(1);
      prev_out <= mipsOut;
      prev_ovf <= overflow;
      if (clr) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        occ       <= '0;
        dropped   <= 1'b0;
        ovfSticky <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        if (do_push && !do_pop)
          occ <= occ + (AW+1)'(1);
        else if (do_pop && !do_push)
          occ <= occ - (AW+1)'(1);
        if (lost)     dropped   <= 1'b1;
        if (overflow) ovfSticky <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the read port is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: tb/tb_mips_out_capture.sv
// Directed bench for mips_out_capture: vector table for single-cycle behaviour plus fill, full push/pop, wrap and async reset sequences.
module tb_mips_out_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mipsOut;
  logic        overflow;
  logic        capEn;
  logic        clr;
  logic        rdReady;
  logic        rdValid;
  logic [31:0] rdData;
  logic [15:0] rdStamp;
  logic        rdOvf;
  logic [3:0]  count;
  logic        full;
  logic        dropped;
  logic        ovfSticky;
  logic [15:0] cycleCnt;

  int checks = 0;
  int errors = 0;
  int exp_cyc = 0;

  typedef struct {
    logic [31:0] mo;
    logic        ovf;
    logic        cap;
    logic        clr;
    logic        rdy;
    logic        vld;
    logic [31:0] dat;
    logic [15:0] stamp;
    logic        rovf;
    logic [3:0]  cnt;
    logic        drop;
    logic        ovfs;
  } vec_t;

  vec_t tbl[$];

  mips_out_capture #(.DATA_W(32), .DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mipsOut(mipsOut), .overflow(overflow), .capEn(capEn),
    .clr(clr), .rdReady(rdReady), .rdValid(rdValid), .rdData(rdData), .rdStamp(rdStamp),
    .rdOvf(rdOvf), .count(count), .full(full), .dropped(dropped), .ovfSticky(ovfSticky),
    .cycleCnt(cycleCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    exp_cyc++;
    chk("cycleCnt", 64'(cycleCnt), 64'(exp_cyc));
  endtask

  task automatic add(input logic [31:0] mo, input logic ovf, input logic cap, input logic cl,
                     input logic rdy, input logic vld, input logic [31:0] dat, input logic [15:0] stamp,
                     input logic rovf, input logic [3:0] cnt, input logic drop, input logic ovfs);
    vec_t v;
    v.mo = mo; v.ovf = ovf; v.cap = cap; v.clr = cl; v.rdy = rdy;
    v.vld = vld; v.dat = dat; v.stamp = stamp; v.rovf = rovf;
    v.cnt = cnt; v.drop = drop; v.ovfs = ovfs;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_d;
    int          s;
    int          s_aa;

    // Rows apply in cycles 10..23 after the idle phase.
    add(32'h5,        0, 1, 0, 0, 1, 32'h5,        16'd10, 0, 4'd1, 0, 0);
    add(32'h5,        0, 1, 0, 1, 0, 32'h0,        16'd0,  0, 4'd0, 0, 0);
    add(32'h7FFFFFFF, 0, 1, 0, 0, 1, 32'h7FFFFFFF, 16'd12, 0, 4'd1, 0, 0);
    add(32'h7FFFFFFF, 1, 1, 0, 1, 1, 32'h7FFFFFFF, 16'd13, 1, 4'd1, 0, 1);
    add(32'h7FFFFFFF, 1, 1, 0, 0, 1, 32'h7FFFFFFF, 16'd13, 1, 4'd1, 0, 1);
    add(32'h7FFFFFFF, 1, 1, 0, 0, 1, 32'h7FFFFFFF, 16'd13, 1, 4'd1, 0, 1);
    add(32'h7FFFFFFF, 0, 1, 0, 1, 0, 32'h0,        16'd0,  0, 4'd0, 0, 1);
    add(32'h7FFFFFFF, 0, 1, 1, 0, 0, 32'h0,        16'd0,  0, 4'd0, 0, 0);
    add(32'h123,      0, 1, 1, 0, 0, 32'h0,        16'd0,  0, 4'd0, 0, 0);
    add(32'h123,      0, 1, 0, 0, 0, 32'h0,        16'd0,  0, 4'd0, 0, 0);
    add(32'h456,      0, 0, 0, 0, 0, 32'h0,        16'd0,  0, 4'd0, 0, 0);
    add(32'h456,      0, 1, 0, 0, 0, 32'h0,        16'd0,  0, 4'd0, 0, 0);
    add(32'h456,      1, 0, 0, 0, 0, 32'h0,        16'd0,  0, 4'd0, 0, 1);
    add(32'h456,      0, 1, 1, 0, 0, 32'h0,        16'd0,  0, 4'd0, 0, 0);

    rst = 1'b1; mipsOut = '0; overflow = 1'b0; capEn = 1'b1; clr = 1'b0; rdReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cycleCnt", 64'(cycleCnt), 64'd0);
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_rdValid",  64'(rdValid),  64'd0);
    chk("rst_full",     64'(full),     64'd0);
    chk("rst_dropped",  64'(dropped),  64'd0);
    chk("rst_ovfSticky",64'(ovfSticky),64'd0);
    chk("rst_rdData",   64'(rdData),   64'd0);
    rst = 1'b0;
    exp_cyc = 0;

    // Constant zero result produces no entries.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_count",   64'(count),   64'd0);
      chk("idle_rdValid", 64'(rdValid), 64'd0);
    end

    foreach (tbl[i]) begin
      mipsOut = tbl[i].mo; overflow = tbl[i].ovf; capEn = tbl[i].cap;
      clr = tbl[i].clr; rdReady = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_rdValid", i),   64'(rdValid),   64'(tbl[i].vld));
      chk($sformatf("vec%0d_rdData", i),    64'(rdData),    64'(tbl[i].dat));
      chk($sformatf("vec%0d_rdStamp", i),   64'(rdStamp),   64'(tbl[i].stamp));
      chk($sformatf("vec%0d_rdOvf", i),     64'(rdOvf),     64'(tbl[i].rovf));
      chk($sformatf("vec%0d_count", i),     64'(count),     64'(tbl[i].cnt));
      chk($sformatf("vec%0d_full", i),      64'(full),      64'(tbl[i].cnt == 4'd8));
      chk($sformatf("vec%0d_dropped", i),   64'(dropped),   64'(tbl[i].drop));
      chk($sformatf("vec%0d_ovfSticky", i), 64'(ovfSticky), 64'(tbl[i].ovfs));
    end
    clr = 1'b0; capEn = 1'b1; overflow = 1'b0; rdReady = 1'b0;

    // Fill past capacity: values 1..10 starting in cycle 24.
    s = exp_cyc;
    for (int i = 1; i <= 10; i++) begin
      mipsOut = 32'(i);
      step();
      chk("fill_count",   64'(count),   64'((i < 8) ? i : 8));
      chk("fill_full",    64'(full),    64'(i >= 8));
      chk("fill_dropped", 64'(dropped), 64'(i >= 9));
      chk("fill_head",    64'(rdData),  64'd1);
    end
    rdReady = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("drain_rdValid", 64'(rdValid), 64'd1);
      chk("drain_rdData",  64'(rdData),  64'(k));
      chk("drain_rdStamp", 64'(rdStamp), 64'(s + k - 1));
      step();
    end
    chk("drain_empty",   64'(rdValid), 64'd0);
    chk("drain_count",   64'(count),   64'd0);
    chk("drain_dropped", 64'(dropped), 64'd1);
    rdReady = 1'b0;

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_dropped", 64'(dropped), 64'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) begin
      mipsOut = 32'h10 + 32'(i);
      step();
    end
    chk("pp_full_pre",  64'(full),  64'd1);
    chk("pp_count_pre", 64'(count), 64'd8);
    mipsOut = 32'hAA; rdReady = 1'b1;
    s_aa = exp_cyc;
    step();
    chk("pp_count",   64'(count),   64'd8);
    chk("pp_dropped", 64'(dropped), 64'd0);
    chk("pp_head",    64'(rdData),  64'h11);
    for (int k = 0; k < 8; k++) begin
      exp_d = (k < 7) ? 32'h11 + 32'(k) : 32'hAA;
      chk("pp_drain_rdData", 64'(rdData), 64'(exp_d));
      if (k == 7) chk("pp_aa_stamp", 64'(rdStamp), 64'(s_aa));
      step();
    end
    chk("pp_empty",        64'(rdValid), 64'd0);
    chk("pp_dropped_post", 64'(dropped), 64'd0);

    // Streaming through pointer wrap with continuous reads.
    for (int k = 0; k < 20; k++) begin
      mipsOut = 32'h100 + 32'(k);
      s = exp_cyc;
      step();
      chk("wrap_rdValid", 64'(rdValid), 64'd1);
      chk("wrap_rdData",  64'(rdData),  64'(32'h100 + 32'(k)));
      chk("wrap_rdStamp", 64'(rdStamp), 64'(s));
      chk("wrap_count",   64'(count),   64'd1);
    end
    step();
    chk("wrap_empty", 64'(rdValid), 64'd0);

    // Asynchronous reset mid-cycle with three entries held.
    rdReady = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      mipsOut = 32'h200 + 32'(k);
      step();
    end
    chk("hold_count", 64'(count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rdValid",  64'(rdValid),  64'd0);
    chk("arst_count",    64'(count),    64'd0);
    chk("arst_cycleCnt", 64'(cycleCnt), 64'd0);
    chk("arst_rdData",   64'(rdData),   64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cyc = 0;
    // Nonzero result right after reset differs from the cleared history.
    step();
    chk("post_rst_count",   64'(count),   64'd1);
    chk("post_rst_rdData",  64'(rdData),  64'h203);
    chk("post_rst_rdStamp", 64'(rdStamp), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
